set_bit_iterator: RTL and testbench

//   Consumes one DATA_WIDTH word per valid/ready handshake and emits the bit index of

---
 rtl/set_bit_iterator.sv | 124 ++++++++++++
 tb/tb_set_bit_iterator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/set_bit_iterator.sv
// Walks each accepted word LSB-first and emits one set-bit index per output beat (zero word -> DATA_WIDTH).
// Optional feature macro SBI_BACK_TO_BACK_EN: accept the next word in the cycle the last beat retires.
module set_bit_iterator #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          din_valid,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic                          din_ready,
    output logic                          dout_valid,
    output logic [$clog2(DATA_WIDTH):0]   dout,
    output logic                          dout_last,
    input  logic                          dout_ready
);

    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [IDX_W-1:0]        dout_q, dout_d;
    logic                    last_q, last_d;

    logic                    ready_int;
    logic                    accept_in;
    logic                    beat_done;
    logic                    update;
    logic [DATA_WIDTH-1:0]   src_word;
    logic [DATA_WIDTH-1:0]   stripped;

    // Lowest set bit wins; an all-zero word falls through to DATA_WIDTH.
    function automatic logic [IDX_W-1:0] tz(input logic [DATA_WIDTH-1:0] w);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (w[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic at_most_one(input logic [DATA_WIDTH-1:0] w);
        return (w & (w - DATA_WIDTH'(1))) == '0;
    endfunction

    assign accept_in = din_valid & din_ready;
    assign beat_done = dout_valid & dout_ready;
    assign stripped  = work_q & (work_q - DATA_WIDTH'(1));

    // State register and registered datapath.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            dout_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
            last_q  <= last_d;
        end
    end

    // Next-state and next-datapath logic.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        dout_d   = dout_q;
        last_d   = last_q;
        update   = 1'b0;
        src_word = stripped;

        unique case (state_q)
            IDLE: begin
                if (accept_in) begin
                    src_word = din;
                    update   = 1'b1;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (beat_done) begin
                    if (!last_q) begin
                        update = 1'b1;
                    end else if (accept_in) begin
                        src_word = din;
                        update   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Index and last flag are precomputed here so the outputs come straight from flops.
        if (update) begin
            work_d = src_word;
            dout_d = tz(src_word);
            last_d = at_most_one(src_word);
        end
    end

    // Output logic.
    always_comb begin
`ifdef SBI_BACK_TO_BACK_EN
        ready_int = (state_q == IDLE) | ((state_q == SCAN) & dout_ready & last_q);
`else
        ready_int = (state_q == IDLE);
`endif
        din_ready  = ready_int & ~reset;
        dout_valid = (state_q == SCAN);
        dout       = dout_q;
        dout_last  = last_q;
    end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Randomised self-checking bench for set_bit_iterator against a queue-based reference of set-bit indices.
// Expected timing of back-to-back words follows SBI_BACK_TO_BACK_EN when defined.
module tb_set_bit_iterator;

    localparam int W     = 32;
    localparam int IDX_W = $clog2(W) + 1;

    logic             clk;
    logic             reset;
    logic             din_valid;
    logic [W-1:0]     din;
    logic             din_ready;
    logic             dout_valid;
    logic [IDX_W-1:0] dout;
    logic             dout_last;
    logic             dout_ready;

    int checks;
    int errors;

    set_bit_iterator #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_last  (dout_last),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic busy_ready_exp(input logic rdy, input logic last);
`ifdef SBI_BACK_TO_BACK_EN
        return rdy & last;
`else
        return 1'b0 & rdy & last;
`endif
    endfunction

    // Reference: list every set bit index in ascending order; a zero word yields one index W.
    task automatic run_word(input logic [W-1:0] word, input int ready_pct);
        int q[$];
        int cycles;
        logic stalled;
        logic [IDX_W-1:0] held_dout;
        logic held_last;
        for (int i = 0; i < W; i++) if (word[i]) q.push_back(i);
        if (q.size() == 0) q.push_back(W);

        @(negedge clk);
        din = word; din_valid = 1'b1; dout_ready = 1'b0;
        #1;
        check("idle_ready", din_ready, 1);
        check("idle_valid", dout_valid, 0);
        @(negedge clk);
        din_valid = 1'b0; din = '0;
        cycles = 0; stalled = 1'b0; held_dout = '0; held_last = 1'b0;
        while (q.size() > 0 && cycles < 500) begin
            check("beat_valid", dout_valid, 1);
            if (stalled) begin
                check("hold_dout", dout, held_dout);
                check("hold_last", dout_last, held_last);
            end
            check("dout", dout, q[0]);
            check("dout_last", dout_last, (q.size() == 1));
            dout_ready = ($urandom_range(99) < ready_pct);
            #1;
            check("busy_ready", din_ready, busy_ready_exp(dout_ready, q.size() == 1));
            if (dout_ready) begin
                void'(q.pop_front());
                stalled = 1'b0;
            end else begin
                stalled = 1'b1; held_dout = dout; held_last = dout_last;
            end
            @(negedge clk);
            cycles++;
        end
        check("beats_done", q.size(), 0);
        check("post_valid", dout_valid, 0);
        check("post_ready", din_ready, 1);
        dout_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;
        checks = 0; errors = 0;
        reset = 1'b1; din_valid = 1'b0; din = '0; dout_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_last", dout_last, 0);
        check("rst_ready", din_ready, 0);
        reset = 1'b0;
        #1;
        check("rel_ready", din_ready, 1);

        // Directed boundary cases
        run_word(32'h0000_0000, 100);
        run_word(32'h8000_0001, 100);
        run_word(32'hFFFF_FFFF, 100);
        run_word(32'h0000_0050, 40);
        run_word(32'h8000_0000, 60);
        run_word(32'h0000_0001, 100);

        // Mid-scan reset after beat 8 of 0xF00
        @(negedge clk);
        din = 32'h0000_0F00; din_valid = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check("rs_beat8", dout, 8);
        @(negedge clk);
        check("rs_beat9_shown", dout, 9);
        reset = 1'b1;
        #1;
        check("rs_valid", dout_valid, 0);
        check("rs_ready", din_ready, 0);
        check("rs_dout", dout, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rs_no_beats", dout_valid, 0);
            check("rs_idle_ready", din_ready, 1);
            @(negedge clk);
        end

        // Two words back to back with din_valid held
        din = 32'h1; din_valid = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        check("b2b_first_valid", dout_valid, 1);
        check("b2b_first_dout", dout, 0);
        check("b2b_first_last", dout_last, 1);
        din = 32'h2;
        @(negedge clk);
`ifdef SBI_BACK_TO_BACK_EN
        din_valid = 1'b0;
        check("b2b_second_valid", dout_valid, 1);
        check("b2b_second_dout", dout, 1);
        check("b2b_second_last", dout_last, 1);
        @(negedge clk);
        check("b2b_done", dout_valid, 0);
`else
        check("bubble_valid", dout_valid, 0);
        check("bubble_ready", din_ready, 1);
        @(negedge clk);
        din_valid = 1'b0;
        check("b2b_second_valid", dout_valid, 1);
        check("b2b_second_dout", dout, 1);
        check("b2b_second_last", dout_last, 1);
        @(negedge clk);
        check("b2b_done", dout_valid, 0);
`endif
        dout_ready = 1'b0;

        // Random words of varying density
        for (int k = 0; k < 40; k++) begin
            w = $urandom;
            case (k % 4)
                1: w = w & $urandom;
                2: w = w & $urandom & $urandom;
                3: w = W'(1) << $urandom_range(W - 1);
                default: ;
            endcase
            run_word(w, 30 + int'($urandom_range(70)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
